commit_msg_intake: RTL and testbench

//  Upstream of the commit engine. Accepts one UDP message per transaction: a udp_info header,

---
 rtl/beehive_udp_msg.sv | 18 +
 rtl/beehive_vr_pkg.sv | 32 +++
 rtl/commit_msg_intake_ctrl.sv | 180 ++++++++++++++++++
 rtl/commit_msg_intake_datap.sv | 75 +++++++
 rtl/commit_msg_intake.sv | 105 ++++++++++
 tb/tb_commit_msg_intake.sv | 358 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/beehive_udp_msg.sv
// beehive_udp_msg
//   Shared UDP message metadata. udp_info travels alongside every message
//   on the NoC. data_length is the UDP payload length in bytes.
//   No ports (package only).

package beehive_udp_msg;

    localparam int UDP_LEN_W = 16;

    typedef struct packed {
        logic [31:0]          src_ip;
        logic [31:0]          dst_ip;
        logic [15:0]          src_port;
        logic [15:0]          dst_port;
        logic [UDP_LEN_W-1:0] data_length;
    } udp_info;

endpackage

// File: rtl/beehive_vr_pkg.sv
// beehive_vr_pkg
//   Viewstamped-replication message layouts shared by the VR blocks.
//   Every VR message starts with vr_msg_hdr at the MSB end of line 0.
//   msg_type is the most significant field of that header. A COMMIT
//   message follows it directly with commit_msg_hdr.
//   No ports (package only).

package beehive_vr_pkg;

    localparam int VR_MSG_TYPE_W = 8;

    typedef struct packed {
        logic [VR_MSG_TYPE_W-1:0] msg_type;
        logic [7:0]               src_id;
        logic [15:0]              rsvd;
    } vr_msg_hdr;

    localparam int VR_MSG_HDR_W     = $bits(vr_msg_hdr);
    localparam int VR_MSG_HDR_BYTES = VR_MSG_HDR_W / 8;

    localparam logic [VR_MSG_TYPE_W-1:0] VR_MSG_PREPARE = 8'd1;
    localparam logic [VR_MSG_TYPE_W-1:0] VR_MSG_COMMIT  = 8'd3;

    typedef struct packed {
        logic [31:0] view;
        logic [31:0] opnum;
    } commit_msg_hdr;

    localparam int COMMIT_MSG_HDR_W     = $bits(commit_msg_hdr);
    localparam int COMMIT_MSG_HDR_BYTES = COMMIT_MSG_HDR_W / 8;

endpackage

// File: rtl/commit_msg_intake_ctrl.sv
// commit_msg_intake_ctrl
//   Message-level FSM of the commit intake. Owns every valid/ready output.
//   Optional counters: COMMIT_MSG_INTAKE_STATS_EN.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   src_intake_*_val/_last   source handshakes
//   intake_src_*_rdy         source ready outputs
//   intake_commit_req_val    commit request valid / commit_intake_req_rdy
//   intake_other_*_val       forward-path valids / other_intake_*_rdy
//   is_commit, len_ok        decode flags from the datapath
//   last0_q                  captured last flag of line 0
//   hdr_capture              load the header register
//   line0_capture            load the line 0 register
//   body_sel                 forward path passes the live source line
//   stat_*_cnt               (macro only) event counters

module commit_msg_intake_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        src_intake_hdr_val,
    input  logic        src_intake_data_val,
    input  logic        src_intake_data_last,
    output logic        intake_src_hdr_rdy,
    output logic        intake_src_data_rdy,
    output logic        intake_commit_req_val,
    input  logic        commit_intake_req_rdy,
    output logic        intake_other_hdr_val,
    input  logic        other_intake_hdr_rdy,
    output logic        intake_other_data_val,
    input  logic        other_intake_data_rdy,
    input  logic        is_commit,
    input  logic        len_ok,
    input  logic        last0_q,
    output logic        hdr_capture,
    output logic        line0_capture,
    output logic        body_sel
`ifdef COMMIT_MSG_INTAKE_STATS_EN
    ,
    output logic [31:0] stat_commit_cnt,
    output logic [31:0] stat_drop_cnt,
    output logic [31:0] stat_other_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_L0,
        CMT_OUT,
        DROP,
        FWD_HDR,
        FWD_L0,
        FWD_BODY
    } intake_state_e;

    intake_state_e state, state_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. rst forces every valid and ready low
    // combinationally, so nothing transfers while reset is held, even though
    // the state register already reads IDLE after the first reset edge.
    always_comb begin
        state_next            = state;
        intake_src_hdr_rdy    = 1'b0;
        intake_src_data_rdy   = 1'b0;
        intake_commit_req_val = 1'b0;
        intake_other_hdr_val  = 1'b0;
        intake_other_data_val = 1'b0;
        hdr_capture           = 1'b0;
        line0_capture         = 1'b0;
        body_sel              = 1'b0;

        case (state)
            IDLE: begin
                intake_src_hdr_rdy = 1'b1;
                hdr_capture        = src_intake_hdr_val;
                if (src_intake_hdr_val) begin
                    state_next = WAIT_L0;
                end
            end
            WAIT_L0: begin
                intake_src_data_rdy = 1'b1;
                line0_capture       = src_intake_data_val;
                if (src_intake_data_val) begin
                    if (is_commit && len_ok) begin
                        state_next = CMT_OUT;
                    end else if (is_commit) begin
                        state_next = DROP;
                    end else begin
                        state_next = FWD_HDR;
                    end
                end
            end
            CMT_OUT: begin
                intake_commit_req_val = 1'b1;
                if (commit_intake_req_rdy) begin
                    state_next = last0_q ? IDLE : DROP;
                end
            end
            DROP: begin
                // A single-line undersized COMMIT has nothing left to drain.
                if (last0_q) begin
                    state_next = IDLE;
                end else begin
                    intake_src_data_rdy = 1'b1;
                    if (src_intake_data_val && src_intake_data_last) begin
                        state_next = IDLE;
                    end
                end
            end
            FWD_HDR: begin
                intake_other_hdr_val = 1'b1;
                if (other_intake_hdr_rdy) begin
                    state_next = FWD_L0;
                end
            end
            FWD_L0: begin
                intake_other_data_val = 1'b1;
                if (other_intake_data_rdy) begin
                    state_next = last0_q ? IDLE : FWD_BODY;
                end
            end
            FWD_BODY: begin
                body_sel              = 1'b1;
                intake_other_data_val = src_intake_data_val;
                intake_src_data_rdy   = other_intake_data_rdy;
                if (src_intake_data_val && other_intake_data_rdy && src_intake_data_last) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (rst) begin
            intake_src_hdr_rdy    = 1'b0;
            intake_src_data_rdy   = 1'b0;
            intake_commit_req_val = 1'b0;
            intake_other_hdr_val  = 1'b0;
            intake_other_data_val = 1'b0;
            hdr_capture           = 1'b0;
            line0_capture         = 1'b0;
            body_sel              = 1'b0;
        end
    end

`ifdef COMMIT_MSG_INTAKE_STATS_EN
    logic drop_entry;

    assign drop_entry = (state == WAIT_L0) && src_intake_data_val && is_commit && !len_ok && !rst;

    // Event counters. They wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_commit_cnt <= '0;
            stat_drop_cnt   <= '0;
            stat_other_cnt  <= '0;
        end else begin
            if (intake_commit_req_val && commit_intake_req_rdy) begin
                stat_commit_cnt <= stat_commit_cnt + 32'd1;
            end
            if (drop_entry) begin
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
            end
            if (intake_other_hdr_val && other_intake_hdr_rdy) begin
                stat_other_cnt <= stat_other_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: rtl/commit_msg_intake_datap.sv
// commit_msg_intake_datap
//   Holds the captured message header and line 0. Builds the shifted commit
//   request and muxes the forwarded data line. Decodes the message type and
//   the length check for the controller.
// Ports
//   clk                  clock
//   hdr_capture          load src_intake_hdr into the header register
//   line0_capture        load src_intake_data/_last as line 0
//   body_sel             forward the live source line instead of line 0
//   src_intake_hdr       incoming udp_info
//   src_intake_data      incoming data line
//   src_intake_data_last incoming last flag
//   is_commit            incoming line carries a COMMIT type
//   len_ok               captured length holds both VR and commit headers
//   last0_q              captured last flag of line 0
//   commit_req           line 0 with the VR header shifted out
//   commit_pkt_info      captured header
//   other_hdr            captured header for the forward path
//   other_data/_last     forwarded line and last flag

module commit_msg_intake_datap
    import beehive_udp_msg::*;
    import beehive_vr_pkg::*;
#(
    parameter int NOC_DATA_W = 256
) (
    input  logic                  clk,
    input  logic                  hdr_capture,
    input  logic                  line0_capture,
    input  logic                  body_sel,
    input  udp_info               src_intake_hdr,
    input  logic [NOC_DATA_W-1:0] src_intake_data,
    input  logic                  src_intake_data_last,
    output logic                  is_commit,
    output logic                  len_ok,
    output logic                  last0_q,
    output logic [NOC_DATA_W-1:0] commit_req,
    output udp_info               commit_pkt_info,
    output udp_info               other_hdr,
    output logic [NOC_DATA_W-1:0] other_data,
    output logic                  other_data_last
);

    localparam logic [UDP_LEN_W-1:0] MIN_COMMIT_LEN =
        UDP_LEN_W'(VR_MSG_HDR_BYTES + COMMIT_MSG_HDR_BYTES);

    udp_info               hdr_q;
    logic [NOC_DATA_W-1:0] line0_q;

    // Header and line 0 registers. Their contents are don't-care after
    // reset, so they carry no reset and load only on their handshake.
    always_ff @(posedge clk) begin
        if (hdr_capture) begin
            hdr_q <= src_intake_hdr;
        end
        if (line0_capture) begin
            line0_q <= src_intake_data;
            last0_q <= src_intake_data_last;
        end
    end

    // The type is decoded from the live line so that the controller can
    // pick its next state in the same cycle line 0 is accepted. msg_type is
    // the top field of vr_msg_hdr, so it sits at the very top of the line.
    assign is_commit = (src_intake_data[NOC_DATA_W-1 -: VR_MSG_TYPE_W] == VR_MSG_COMMIT);
    assign len_ok    = (hdr_q.data_length >= MIN_COMMIT_LEN);

    assign commit_req      = {line0_q[NOC_DATA_W-1-VR_MSG_HDR_W:0], {VR_MSG_HDR_W{1'b0}}};
    assign commit_pkt_info = hdr_q;
    assign other_hdr       = hdr_q;

    assign other_data      = body_sel ? src_intake_data      : line0_q;
    assign other_data_last = body_sel ? src_intake_data_last : last0_q;

endmodule

// File: rtl/commit_msg_intake.sv
// commit_msg_intake
//   Front end of the commit engine. Takes one UDP message per transaction
//   (udp_info header, then data lines), decodes the VR type from line 0,
//   hands COMMITs to the commit engine with the VR header stripped, drops
//   undersized COMMITs and forwards every other type unmodified.
//   Optional: define COMMIT_MSG_INTAKE_STATS_EN to add stat_commit_cnt,
//   stat_drop_cnt and stat_other_cnt (32 bits each).
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   src_intake_hdr_val/_hdr           message header in, intake_src_hdr_rdy
//   src_intake_data_val/_data/_last   data lines in, intake_src_data_rdy
//   intake_commit_req_val/_req        commit request, commit_intake_req_rdy
//   intake_commit_pkt_info            header of the committed message
//   intake_other_hdr_val/_hdr         forwarded header, other_intake_hdr_rdy
//   intake_other_data_val/_data/_last forwarded lines, other_intake_data_rdy

module commit_msg_intake
    import beehive_udp_msg::*;
#(
    parameter int NOC_DATA_W = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_intake_hdr_val,
    input  udp_info               src_intake_hdr,
    output logic                  intake_src_hdr_rdy,
    input  logic                  src_intake_data_val,
    input  logic [NOC_DATA_W-1:0] src_intake_data,
    input  logic                  src_intake_data_last,
    output logic                  intake_src_data_rdy,
    output logic                  intake_commit_req_val,
    output logic [NOC_DATA_W-1:0] intake_commit_req,
    output udp_info               intake_commit_pkt_info,
    input  logic                  commit_intake_req_rdy,
    output logic                  intake_other_hdr_val,
    output udp_info               intake_other_hdr,
    input  logic                  other_intake_hdr_rdy,
    output logic                  intake_other_data_val,
    output logic [NOC_DATA_W-1:0] intake_other_data,
    output logic                  intake_other_data_last,
    input  logic                  other_intake_data_rdy
`ifdef COMMIT_MSG_INTAKE_STATS_EN
    ,
    output logic [31:0]           stat_commit_cnt,
    output logic [31:0]           stat_drop_cnt,
    output logic [31:0]           stat_other_cnt
`endif
);

    logic is_commit;
    logic len_ok;
    logic last0_q;
    logic hdr_capture;
    logic line0_capture;
    logic body_sel;

    commit_msg_intake_ctrl u_ctrl (
        .clk                   (clk),
        .rst                   (rst),
        .src_intake_hdr_val    (src_intake_hdr_val),
        .src_intake_data_val   (src_intake_data_val),
        .src_intake_data_last  (src_intake_data_last),
        .intake_src_hdr_rdy    (intake_src_hdr_rdy),
        .intake_src_data_rdy   (intake_src_data_rdy),
        .intake_commit_req_val (intake_commit_req_val),
        .commit_intake_req_rdy (commit_intake_req_rdy),
        .intake_other_hdr_val  (intake_other_hdr_val),
        .other_intake_hdr_rdy  (other_intake_hdr_rdy),
        .intake_other_data_val (intake_other_data_val),
        .other_intake_data_rdy (other_intake_data_rdy),
        .is_commit             (is_commit),
        .len_ok                (len_ok),
        .last0_q               (last0_q),
        .hdr_capture           (hdr_capture),
        .line0_capture         (line0_capture),
        .body_sel              (body_sel)
`ifdef COMMIT_MSG_INTAKE_STATS_EN
        ,
        .stat_commit_cnt       (stat_commit_cnt),
        .stat_drop_cnt         (stat_drop_cnt),
        .stat_other_cnt        (stat_other_cnt)
`endif
    );

    commit_msg_intake_datap #(
        .NOC_DATA_W (NOC_DATA_W)
    ) u_datap (
        .clk                  (clk),
        .hdr_capture          (hdr_capture),
        .line0_capture        (line0_capture),
        .body_sel             (body_sel),
        .src_intake_hdr       (src_intake_hdr),
        .src_intake_data      (src_intake_data),
        .src_intake_data_last (src_intake_data_last),
        .is_commit            (is_commit),
        .len_ok               (len_ok),
        .last0_q              (last0_q),
        .commit_req           (intake_commit_req),
        .commit_pkt_info      (intake_commit_pkt_info),
        .other_hdr            (intake_other_hdr),
        .other_data           (intake_other_data),
        .other_data_last      (intake_other_data_last)
    );

endmodule

// File: tb/tb_commit_msg_intake.sv
// tb_commit_msg_intake
//   Directed bench for commit_msg_intake with 128-bit data lines.
//   Line 0 layout (MSB first): vr_msg_hdr {type, src_id, rsvd} 32 bits,
//   then commit_msg_hdr {view, opnum} 64 bits, then 32 payload bits.
//   Stat counters are checked when COMMIT_MSG_INTAKE_STATS_EN is defined.

module tb_commit_msg_intake;
    import beehive_udp_msg::*;
    import beehive_vr_pkg::*;

    localparam int W = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_intake_hdr_val;
    udp_info       src_intake_hdr;
    logic          intake_src_hdr_rdy;
    logic          src_intake_data_val;
    logic [W-1:0]  src_intake_data;
    logic          src_intake_data_last;
    logic          intake_src_data_rdy;
    logic          intake_commit_req_val;
    logic [W-1:0]  intake_commit_req;
    udp_info       intake_commit_pkt_info;
    logic          commit_intake_req_rdy;
    logic          intake_other_hdr_val;
    udp_info       intake_other_hdr;
    logic          other_intake_hdr_rdy;
    logic          intake_other_data_val;
    logic [W-1:0]  intake_other_data;
    logic          intake_other_data_last;
    logic          other_intake_data_rdy;
`ifdef COMMIT_MSG_INTAKE_STATS_EN
    logic [31:0]   stat_commit_cnt;
    logic [31:0]   stat_drop_cnt;
    logic [31:0]   stat_other_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    int commit_xfers     = 0;
    int other_hdr_xfers  = 0;
    int other_data_xfers = 0;
    int other_last_xfers = 0;

    always #5 clk = ~clk;

    commit_msg_intake #(
        .NOC_DATA_W (W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .src_intake_hdr_val     (src_intake_hdr_val),
        .src_intake_hdr         (src_intake_hdr),
        .intake_src_hdr_rdy     (intake_src_hdr_rdy),
        .src_intake_data_val    (src_intake_data_val),
        .src_intake_data        (src_intake_data),
        .src_intake_data_last   (src_intake_data_last),
        .intake_src_data_rdy    (intake_src_data_rdy),
        .intake_commit_req_val  (intake_commit_req_val),
        .intake_commit_req      (intake_commit_req),
        .intake_commit_pkt_info (intake_commit_pkt_info),
        .commit_intake_req_rdy  (commit_intake_req_rdy),
        .intake_other_hdr_val   (intake_other_hdr_val),
        .intake_other_hdr       (intake_other_hdr),
        .other_intake_hdr_rdy   (other_intake_hdr_rdy),
        .intake_other_data_val  (intake_other_data_val),
        .intake_other_data      (intake_other_data),
        .intake_other_data_last (intake_other_data_last),
        .other_intake_data_rdy  (other_intake_data_rdy)
`ifdef COMMIT_MSG_INTAKE_STATS_EN
        ,
        .stat_commit_cnt        (stat_commit_cnt),
        .stat_drop_cnt          (stat_drop_cnt),
        .stat_other_cnt         (stat_other_cnt)
`endif
    );

    // Transfer counters on the output ports.
    always @(posedge clk) begin
        if (intake_commit_req_val && commit_intake_req_rdy) begin
            commit_xfers <= commit_xfers + 1;
        end
        if (intake_other_hdr_val && other_intake_hdr_rdy) begin
            other_hdr_xfers <= other_hdr_xfers + 1;
        end
        if (intake_other_data_val && other_intake_data_rdy) begin
            other_data_xfers <= other_data_xfers + 1;
            if (intake_other_data_last) begin
                other_last_xfers <= other_last_xfers + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic hv, input udp_info h, input logic dv,
                                 input logic [W-1:0] d, input logic l);
        src_intake_hdr_val   = hv;
        src_intake_hdr       = h;
        src_intake_data_val  = dv;
        src_intake_data      = d;
        src_intake_data_last = l;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkCount(input string tag, input int observed, input int expected);
        compared++;
        assert (observed == expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAllQuiet(input string tag);
        checkFlag({tag, "_hdr_rdy"},   intake_src_hdr_rdy,    1'b0);
        checkFlag({tag, "_data_rdy"},  intake_src_data_rdy,   1'b0);
        checkFlag({tag, "_req_val"},   intake_commit_req_val, 1'b0);
        checkFlag({tag, "_ohdr_val"},  intake_other_hdr_val,  1'b0);
        checkFlag({tag, "_odata_val"}, intake_other_data_val, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        udp_info      h1, h2, h3, h4, h4b, h5, h6, h7;
        logic [W-1:0] l5 [4];
        logic [W-1:0] l6 [3];

        h1  = '{src_ip: 32'h0A00_0001, dst_ip: 32'h0A00_0002, src_port: 16'd4000, dst_port: 16'd5000, data_length: 16'd12};
        h2  = '{src_ip: 32'h0A00_0003, dst_ip: 32'h0A00_0002, src_port: 16'd4001, dst_port: 16'd5000, data_length: 16'd12};
        h3  = '{src_ip: 32'h0A00_0004, dst_ip: 32'h0A00_0002, src_port: 16'd4002, dst_port: 16'd5000, data_length: 16'd48};
        h4  = '{src_ip: 32'h0A00_0005, dst_ip: 32'h0A00_0002, src_port: 16'd4003, dst_port: 16'd5000, data_length: 16'd4};
        h4b = '{src_ip: 32'h0A00_0006, dst_ip: 32'h0A00_0002, src_port: 16'd4004, dst_port: 16'd5000, data_length: 16'd11};
        h5  = '{src_ip: 32'hC0A8_0101, dst_ip: 32'hC0A8_0102, src_port: 16'd7000, dst_port: 16'd7001, data_length: 16'd64};
        h6  = '{src_ip: 32'hC0A8_0201, dst_ip: 32'hC0A8_0202, src_port: 16'd7100, dst_port: 16'd7101, data_length: 16'd48};
        h7  = '{src_ip: 32'h0A00_0007, dst_ip: 32'h0A00_0002, src_port: 16'd4005, dst_port: 16'd5000, data_length: 16'd16};

        l5[0] = 128'h0155_0000_0000_0003_0000_0020_DEAD_BEEF;
        l5[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        l5[2] = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
        l5[3] = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        l6[0] = 128'h0166_0000_0000_0004_0000_0030_0000_0001;
        l6[1] = 128'h6161_6161_6161_6161_6161_6161_6161_6161;
        l6[2] = 128'h6262_6262_6262_6262_6262_6262_6262_6262;

        // Reset
        rst                   = 1'b1;
        commit_intake_req_rdy = 1'b1;
        other_intake_hdr_rdy  = 1'b0;
        other_intake_data_rdy = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        tick();
        checkAllQuiet("reset");
        rst = 1'b0;
        #1;
        checkFlag("idle_hdr_rdy", intake_src_hdr_rdy, 1'b1);

        // 1: minimum-length COMMIT, one line, view 2 / opnum 5
        $display("[TB] minimum-length commit");
        applyStimulus(1'b1, h1, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h1, 1'b1, 128'h0311_0000_0000_0002_0000_0005_CAFE_F00D, 1'b1);
        checkFlag("t1_l0_data_rdy", intake_src_data_rdy, 1'b1);
        checkFlag("t1_l0_hdr_rdy", intake_src_hdr_rdy, 1'b0);
        checkFlag("t1_l0_req_val", intake_commit_req_val, 1'b0);
        tick();
        applyStimulus(1'b0, h1, 1'b0, '0, 1'b0);
        checkFlag("t1_req_val", intake_commit_req_val, 1'b1);
        checkOutput("t1_req", intake_commit_req, 128'h0000_0002_0000_0005_CAFE_F00D_0000_0000);
        checkOutput("t1_view", W'(intake_commit_req[W-1 -: 32]), W'(32'd2));
        checkOutput("t1_opnum", W'(intake_commit_req[W-33 -: 32]), W'(32'd5));
        checkOutput("t1_pkt_info", W'(intake_commit_pkt_info), W'(h1));
        tick();
        checkFlag("t1_done_req_val", intake_commit_req_val, 1'b0);
        checkFlag("t1_done_hdr_rdy", intake_src_hdr_rdy, 1'b1);
        checkCount("t1_commit_xfers", commit_xfers, 1);

        // 2: commit engine stalls for 10 cycles
        $display("[TB] commit backpressure");
        commit_intake_req_rdy = 1'b0;
        applyStimulus(1'b1, h2, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h2, 1'b1, 128'h0322_0000_0000_0002_0000_0007_1234_5678, 1'b1);
        tick();
        applyStimulus(1'b0, h2, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkFlag("t2_hold_req_val", intake_commit_req_val, 1'b1);
            checkOutput("t2_hold_req", intake_commit_req, 128'h0000_0002_0000_0007_1234_5678_0000_0000);
            checkFlag("t2_hold_hdr_rdy", intake_src_hdr_rdy, 1'b0);
            tick();
        end
        checkCount("t2_no_early_xfer", commit_xfers, 1);
        commit_intake_req_rdy = 1'b1;
        #1;
        checkFlag("t2_release_req_val", intake_commit_req_val, 1'b1);
        tick();
        checkFlag("t2_done_req_val", intake_commit_req_val, 1'b0);
        checkCount("t2_commit_xfers", commit_xfers, 2);

        // 3: three-line COMMIT, trailing lines drained
        $display("[TB] multi-line commit");
        applyStimulus(1'b1, h3, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h3, 1'b1, 128'h0333_0000_0000_0009_0000_0010_AAAA_BBBB, 1'b0);
        tick();
        applyStimulus(1'b0, h3, 1'b1, {8{16'h1111}}, 1'b0);
        checkFlag("t3_req_val", intake_commit_req_val, 1'b1);
        checkOutput("t3_req", intake_commit_req, 128'h0000_0009_0000_0010_AAAA_BBBB_0000_0000);
        checkFlag("t3_cmt_data_rdy", intake_src_data_rdy, 1'b0);
        tick();
        checkFlag("t3_drop_req_val", intake_commit_req_val, 1'b0);
        checkFlag("t3_l1_data_rdy", intake_src_data_rdy, 1'b1);
        checkFlag("t3_drop_hdr_rdy", intake_src_hdr_rdy, 1'b0);
        tick();
        applyStimulus(1'b0, h3, 1'b1, {8{16'h2222}}, 1'b1);
        checkFlag("t3_l2_data_rdy", intake_src_data_rdy, 1'b1);
        tick();
        applyStimulus(1'b0, h3, 1'b0, '0, 1'b0);
        checkFlag("t3_idle_hdr_rdy", intake_src_hdr_rdy, 1'b1);
        checkCount("t3_commit_xfers", commit_xfers, 3);

        // 4: undersized COMMITs (header only, and one byte short)
        $display("[TB] undersized commits");
        applyStimulus(1'b1, h4, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h4, 1'b1, 128'h0344_0000_0000_0001_0000_0001_0000_0000, 1'b1);
        checkFlag("t4_l0_data_rdy", intake_src_data_rdy, 1'b1);
        tick();
        applyStimulus(1'b0, h4, 1'b0, '0, 1'b0);
        checkFlag("t4_drop_req_val", intake_commit_req_val, 1'b0);
        checkFlag("t4_drop_data_rdy", intake_src_data_rdy, 1'b0);
        checkFlag("t4_drop_hdr_rdy", intake_src_hdr_rdy, 1'b0);
        tick();
        checkFlag("t4_idle_hdr_rdy", intake_src_hdr_rdy, 1'b1);
        applyStimulus(1'b1, h4b, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h4b, 1'b1, 128'h0345_0000_0000_0001_0000_0002_0000_0000, 1'b1);
        tick();
        applyStimulus(1'b0, h4b, 1'b0, '0, 1'b0);
        checkFlag("t4b_drop_req_val", intake_commit_req_val, 1'b0);
        tick();
        checkFlag("t4b_idle_hdr_rdy", intake_src_hdr_rdy, 1'b1);
        checkCount("t4_commit_xfers", commit_xfers, 3);
`ifdef COMMIT_MSG_INTAKE_STATS_EN
        checkOutput("t4_stat_drop", W'(stat_drop_cnt), W'(32'd2));
`endif

        // 5: PREPARE forwarded, downstream ready toggling
        $display("[TB] prepare forward");
        other_intake_hdr_rdy = 1'b1;
        applyStimulus(1'b1, h5, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h5, 1'b1, l5[0], 1'b0);
        tick();
        applyStimulus(1'b0, h5, 1'b0, '0, 1'b0);
        checkFlag("t5_ohdr_val", intake_other_hdr_val, 1'b1);
        checkOutput("t5_ohdr", W'(intake_other_hdr), W'(h5));
        checkFlag("t5_fwdhdr_data_rdy", intake_src_data_rdy, 1'b0);
        tick();
        other_intake_data_rdy = 1'b1;
        applyStimulus(1'b0, h5, 1'b1, l5[1], 1'b0);
        checkFlag("t5_l0_val", intake_other_data_val, 1'b1);
        checkOutput("t5_l0_data", intake_other_data, l5[0]);
        checkFlag("t5_l0_last", intake_other_data_last, 1'b0);
        checkFlag("t5_l0_src_rdy", intake_src_data_rdy, 1'b0);
        tick();
        for (int i = 1; i < 4; i++) begin
            other_intake_data_rdy = 1'b0;
            applyStimulus(1'b0, h5, 1'b1, l5[i], (i == 3));
            checkFlag("t5_body_val", intake_other_data_val, 1'b1);
            checkOutput("t5_body_data", intake_other_data, l5[i]);
            checkFlag("t5_body_last", intake_other_data_last, (i == 3));
            checkFlag("t5_body_stall_rdy", intake_src_data_rdy, 1'b0);
            tick();
            other_intake_data_rdy = 1'b1;
            #1;
            checkFlag("t5_body_rdy", intake_src_data_rdy, 1'b1);
            checkOutput("t5_body_data_held", intake_other_data, l5[i]);
            tick();
        end
        applyStimulus(1'b0, h5, 1'b0, '0, 1'b0);
        checkFlag("t5_idle_hdr_rdy", intake_src_hdr_rdy, 1'b1);
        checkFlag("t5_idle_odata_val", intake_other_data_val, 1'b0);
        checkCount("t5_other_hdr_xfers", other_hdr_xfers, 1);
        checkCount("t5_other_data_xfers", other_data_xfers, 4);
        checkCount("t5_other_last_xfers", other_last_xfers, 1);
        checkCount("t5_commit_xfers", commit_xfers, 3);

        // 6: reset in the middle of a forwarded body
        $display("[TB] reset mid-message");
        applyStimulus(1'b1, h6, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h6, 1'b1, l6[0], 1'b0);
        tick();
        applyStimulus(1'b0, h6, 1'b0, '0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, h6, 1'b1, l6[1], 1'b0);
        checkOutput("t6_l1_data", intake_other_data, l6[1]);
        tick();
        applyStimulus(1'b0, h6, 1'b1, l6[2], 1'b0);
        rst = 1'b1;
        #1;
        checkAllQuiet("t6_rst_pre");
        tick();
        checkAllQuiet("t6_rst_post");
        rst = 1'b0;
        applyStimulus(1'b0, h6, 1'b0, '0, 1'b0);
        checkFlag("t6_idle_hdr_rdy", intake_src_hdr_rdy, 1'b1);
        checkCount("t6_other_data_xfers", other_data_xfers, 6);
        applyStimulus(1'b1, h7, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(1'b0, h7, 1'b1, 128'h0377_0000_0000_0004_0000_0008_0BAD_F00D, 1'b1);
        tick();
        applyStimulus(1'b0, h7, 1'b0, '0, 1'b0);
        checkFlag("t6_req_val", intake_commit_req_val, 1'b1);
        checkOutput("t6_req", intake_commit_req, 128'h0000_0004_0000_0008_0BAD_F00D_0000_0000);
        checkOutput("t6_pkt_info", W'(intake_commit_pkt_info), W'(h7));
        tick();
        checkCount("t6_commit_xfers", commit_xfers, 4);
`ifdef COMMIT_MSG_INTAKE_STATS_EN
        checkOutput("stat_commit", W'(stat_commit_cnt), W'(32'd1));
        checkOutput("stat_drop", W'(stat_drop_cnt), W'(32'd0));
        checkOutput("stat_other", W'(stat_other_cnt), W'(32'd0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
